stream_packet_gen: RTL and testbench

STREAM_PACKET_GEN -- requirements
Module: stream_packet_gen

---
 rtl/stream_packet_gen_pkg.sv | 32 +++
 rtl/stream_packet_gen_csr.sv | 137 +++++++++++++
 rtl/stream_packet_gen.sv | 132 +++++++++++++
 tb/tb_stream_packet_gen.sv | 342 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/stream_packet_gen_pkg.sv
// Shared types and constants for the stream_packet_gen block: FSM states,
// CSR address map, CTRL bit positions and register reset values.
package stream_packet_gen_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    localparam logic [1:0] CSR_ADDR_CTRL = 2'd0;
    localparam logic [1:0] CSR_ADDR_LEN  = 2'd1;
    localparam logic [1:0] CSR_ADDR_CNT  = 2'd2;
    localparam logic [1:0] CSR_ADDR_SENT = 2'd3;

    localparam int CTRL_START_BIT = 0;
    localparam int CTRL_ABORT_BIT = 1;
    localparam int CTRL_BUSY_BIT  = 2;

    localparam logic [15:0] LEN_RESET = 16'd64;
    localparam logic [15:0] CNT_RESET = 16'd1;

    // CTRL readback: busy flag plus the stall counter in the upper half.
    function automatic logic [31:0] pack_ctrl(input logic busy, input logic [15:0] stall_cnt);
        logic [31:0] v;
        v                = '0;
        v[CTRL_BUSY_BIT] = busy;
        v[31:16]         = stall_cnt;
        return v;
    endfunction

endpackage

// File: rtl/stream_packet_gen_csr.sv
// CSR register file, command decode and readLatency-1 response pipeline.
// Optional STREAM_PACKET_GEN_STALL_CNT_EN adds a saturating stall counter in CTRL[31:16].
module stream_packet_gen_csr
    import stream_packet_gen_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic [1:0]  csr_address,
    input  logic        csr_read,
    input  logic        csr_write,
    input  logic [31:0] csr_writedata,
    output logic [31:0] csr_readdata,
    output logic        csr_readdatavalid,
    output logic        csr_waitrequest,
    input  logic        i_busy,
    input  logic        i_eop_accept,
`ifdef STREAM_PACKET_GEN_STALL_CNT_EN
    input  logic        i_stall,
`endif
    output logic        o_start,
    output logic        o_abort,
    output logic        o_last_packet,
    output logic [15:0] o_len
);

    logic [15:0] r_len;
    logic [15:0] r_cnt;
    logic [31:0] r_sent;
    logic        r_abort;
    logic [31:0] r_readdata;
    logic        r_readdatavalid;

    logic        w_busy_stall;
    logic        w_wr;
    logic        w_rd;
    logic        w_ctrl_wr;
    logic        w_abort_wr;
    logic [15:0] w_stall_cnt;
    logic [31:0] w_rdata;
    logic        w_unused_wdata;

    // Only LEN/CNT/SENT writes stall, and only while a run is in progress, so
    // the programmed length cannot change under the beat formatter.
    assign w_busy_stall    = i_busy && csr_write && (csr_address != CSR_ADDR_CTRL);
    assign csr_waitrequest = !reset_n || w_busy_stall;

    assign w_wr      = csr_write && !w_busy_stall;
    assign w_rd      = csr_read;
    assign w_ctrl_wr = w_wr && (csr_address == CSR_ADDR_CTRL);

    assign o_start    = w_ctrl_wr && csr_writedata[CTRL_START_BIT] && !i_busy
                        && (r_len != 16'd0) && (r_cnt != 16'd0);
    assign w_abort_wr = w_ctrl_wr && csr_writedata[CTRL_ABORT_BIT] && i_busy;
    assign o_abort    = r_abort || w_abort_wr;

    assign o_last_packet = (r_sent == {16'h0000, r_cnt});
    assign o_len         = r_len;

    assign w_unused_wdata = ^csr_writedata[31:16];

    // NOTE: state elements use non-blocking assignments so every flop samples
    // the pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_len <= LEN_RESET;
            r_cnt <= CNT_RESET;
        end else if (w_wr) begin
            if (csr_address == CSR_ADDR_LEN) r_len <= csr_writedata[15:0];
            if (csr_address == CSR_ADDR_CNT) r_cnt <= csr_writedata[15:0];
        end
    end

    // Start (idle only) and eop acceptance (busy only) are mutually exclusive.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sent <= '0;
        end else if (o_start) begin
            r_sent <= '0;
        end else if (i_eop_accept) begin
            r_sent <= r_sent + 32'd1;
        end
    end

    // Pending abort lives only while busy; returning to IDLE consumes it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_abort <= 1'b0;
        end else begin
            r_abort <= i_busy && o_abort;
        end
    end

`ifdef STREAM_PACKET_GEN_STALL_CNT_EN
    logic [15:0] r_stall_cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_stall_cnt <= '0;
        end else if (o_start) begin
            r_stall_cnt <= '0;
        end else if (i_stall && (r_stall_cnt != 16'hFFFF)) begin
            r_stall_cnt <= r_stall_cnt + 16'd1;
        end
    end

    assign w_stall_cnt = r_stall_cnt;
`else
    assign w_stall_cnt = '0;
`endif

    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        w_rdata = '0;
        case (csr_address)
            CSR_ADDR_CTRL: w_rdata = pack_ctrl(i_busy, w_stall_cnt);
            CSR_ADDR_LEN:  w_rdata = {16'h0000, r_len};
            CSR_ADDR_CNT:  w_rdata = {16'h0000, r_cnt};
            CSR_ADDR_SENT: w_rdata = r_sent;
            default:       w_rdata = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_readdatavalid <= 1'b0;
            r_readdata      <= '0;
        end else begin
            r_readdatavalid <= w_rd;
            if (w_rd) r_readdata <= w_rdata;
        end
    end

    assign csr_readdata      = r_readdata;
    assign csr_readdatavalid = r_readdatavalid;

endmodule

// File: rtl/stream_packet_gen.sv
// Avalon-ST packet generator: FSM (IDLE/SEND/GAP) and beat formatter, CSRs in a sub-module.
// Optional STREAM_PACKET_GEN_STALL_CNT_EN adds a valid-while-not-ready counter in CTRL[31:16].
module stream_packet_gen
    import stream_packet_gen_pkg::*;
#(
    parameter int DATA_BYTES = 8
) (
    input  logic                          clk,
    input  logic                          reset_n,
    output logic [DATA_BYTES*8-1:0]       stream_out_data,
    output logic [$clog2(DATA_BYTES)-1:0] stream_out_empty,
    output logic                          stream_out_valid,
    output logic                          stream_out_startofpacket,
    output logic                          stream_out_endofpacket,
    input  logic                          stream_out_ready,
    input  logic [1:0]                    csr_address,
    input  logic                          csr_read,
    input  logic                          csr_write,
    input  logic [31:0]                   csr_writedata,
    output logic [31:0]                   csr_readdata,
    output logic                          csr_readdatavalid,
    output logic                          csr_waitrequest
);

    localparam int          EMPTY_W   = $clog2(DATA_BYTES);
    localparam logic [16:0] BEAT_STEP = 17'(DATA_BYTES);

    state_t      r_state;
    state_t      w_state_next;
    logic [16:0] r_off;
    logic [16:0] w_off_next;

    logic        w_busy;
    logic        w_start;
    logic        w_abort;
    logic        w_last_packet;
    logic        w_accept;
    logic        w_sop;
    logic        w_eop;
    logic [15:0] w_len;
    logic [16:0] w_len_ext;
    logic [16:0] w_off_end;

    stream_packet_gen_csr u_csr (
        .clk               (clk),
        .reset_n           (reset_n),
        .csr_address       (csr_address),
        .csr_read          (csr_read),
        .csr_write         (csr_write),
        .csr_writedata     (csr_writedata),
        .csr_readdata      (csr_readdata),
        .csr_readdatavalid (csr_readdatavalid),
        .csr_waitrequest   (csr_waitrequest),
        .i_busy            (w_busy),
        .i_eop_accept      (w_accept && w_eop),
`ifdef STREAM_PACKET_GEN_STALL_CNT_EN
        .i_stall           (stream_out_valid && !stream_out_ready),
`endif
        .o_start           (w_start),
        .o_abort           (w_abort),
        .o_last_packet     (w_last_packet),
        .o_len             (w_len)
    );

    // r_off is the packet byte offset of the current beat; it only moves on an
    // accepted beat, which keeps every output stable while the sink stalls.
    assign w_busy    = (r_state != ST_IDLE);
    assign w_len_ext = {1'b0, w_len};
    assign w_off_end = r_off + BEAT_STEP;
    assign w_sop     = (r_off == 17'd0);
    assign w_eop     = (w_off_end >= w_len_ext);
    assign w_accept  = stream_out_valid && stream_out_ready;

    assign stream_out_valid         = (r_state == ST_SEND);
    assign stream_out_startofpacket = stream_out_valid && w_sop;
    assign stream_out_endofpacket   = stream_out_valid && w_eop;
    assign stream_out_empty         = stream_out_endofpacket ? EMPTY_W'(w_off_end - w_len_ext)
                                                             : '0;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
            r_off   <= '0;
        end else begin
            r_state <= w_state_next;
            r_off   <= w_off_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_off_next   = r_off;
        unique case (r_state)
            ST_IDLE: begin
                if (w_start) begin
                    w_state_next = ST_SEND;
                    w_off_next   = '0;
                end
            end
            ST_SEND: begin
                if (w_accept) begin
                    if (w_eop) begin
                        w_state_next = ST_GAP;
                        w_off_next   = '0;
                    end else begin
                        w_off_next = w_off_end;
                    end
                end
            end
            ST_GAP: begin
                w_state_next = (w_last_packet || w_abort) ? ST_IDLE : ST_SEND;
            end
            default: begin
                w_state_next = ST_IDLE;
                w_off_next   = '0;
            end
        endcase
    end

    // Byte j of the beat sits in the high-order lane first; bytes past LEN are 0.
    always_comb begin
        stream_out_data = '0;
        if (stream_out_valid) begin
            for (int j = 0; j < DATA_BYTES; j++) begin
                if ((r_off + 17'(j)) < w_len_ext) begin
                    stream_out_data[(DATA_BYTES-1-j)*8 +: 8] = r_off[7:0] + 8'(j);
                end
            end
        end
    end

endmodule

// File: tb/tb_stream_packet_gen.sv
// Directed bench for stream_packet_gen (DATA_BYTES=8): table of expected beats
// plus hand-written sequences for gaps, stalls, abort, busy writes and reset.
`timescale 1ns/1ps
module tb_stream_packet_gen;
    import stream_packet_gen_pkg::*;

    localparam int DATA_BYTES = 8;
`ifdef STREAM_PACKET_GEN_STALL_CNT_EN
    localparam logic [15:0] EXP_STALL = 16'd2;
`else
    localparam logic [15:0] EXP_STALL = 16'd0;
`endif

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [63:0] stream_out_data;
    logic [2:0]  stream_out_empty;
    logic        stream_out_valid;
    logic        stream_out_startofpacket;
    logic        stream_out_endofpacket;
    logic        stream_out_ready = 1'b0;
    logic [1:0]  csr_address = '0;
    logic        csr_read = 1'b0;
    logic        csr_write = 1'b0;
    logic [31:0] csr_writedata = '0;
    logic [31:0] csr_readdata;
    logic        csr_readdatavalid;
    logic        csr_waitrequest;

    stream_packet_gen #(.DATA_BYTES(DATA_BYTES)) dut (
        .clk                      (clk),
        .reset_n                  (reset_n),
        .stream_out_data          (stream_out_data),
        .stream_out_empty         (stream_out_empty),
        .stream_out_valid         (stream_out_valid),
        .stream_out_startofpacket (stream_out_startofpacket),
        .stream_out_endofpacket   (stream_out_endofpacket),
        .stream_out_ready         (stream_out_ready),
        .csr_address              (csr_address),
        .csr_read                 (csr_read),
        .csr_write                (csr_write),
        .csr_writedata            (csr_writedata),
        .csr_readdata             (csr_readdata),
        .csr_readdatavalid        (csr_readdatavalid),
        .csr_waitrequest          (csr_waitrequest)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] data;
        logic [2:0]  empty;
        logic        sop;
        logic        eop;
    } beat_t;

    typedef struct {
        logic        run;
        logic [15:0] len;
        int          n_beats;
        int          beat;
        logic [63:0] data;
        logic [2:0]  empty;
        logic        sop;
        logic        eop;
    } vec_t;

    localparam int NV = 9;
    vec_t  vecs[NV];
    beat_t q_beats[$];
    logic  cap_en = 1'b0;
    int    n_cmp = 0;
    int    n_err = 0;

    always @(negedge clk) begin
        if (cap_en && stream_out_valid && stream_out_ready)
            q_beats.push_back('{stream_out_data, stream_out_empty,
                                stream_out_startofpacket, stream_out_endofpacket});
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic csr_wr(input logic [1:0] a, input logic [31:0] d, output int stalls);
        logic stalled;
        bit   done;
        csr_address   = a;
        csr_writedata = d;
        csr_write     = 1'b1;
        stalls        = 0;
        done          = 0;
        for (int n = 0; n < 500 && !done; n++) begin
            @(negedge clk);
            stalled = csr_waitrequest;
            tick();
            if (!stalled) done = 1;
            else stalls++;
        end
        if (!done) begin
            n_cmp++;
            n_err++;
            $display("FAIL csr_wr timeout: addr %0d still stalled after 500 cycles", a);
        end
        csr_write = 1'b0;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        int s;
        csr_wr(a, d, s);
    endtask

    task automatic csr_rd(input logic [1:0] a, output logic [31:0] d);
        csr_address = a;
        csr_read    = 1'b1;
        tick();
        csr_read = 1'b0;
        @(negedge clk);
        check("readdatavalid", csr_readdatavalid, 1);
        d = csr_readdata;
        tick();
    endtask

    task automatic wait_idle();
        logic [31:0] v;
        bit          done;
        done = 0;
        for (int i = 0; i < 400 && !done; i++) begin
            csr_rd(CSR_ADDR_CTRL, v);
            if (!v[CTRL_BUSY_BIT]) done = 1;
        end
        if (!done) begin
            n_cmp++;
            n_err++;
            $display("FAIL wait_idle: busy still 1 after 400 polls");
        end
    endtask

    initial begin
        logic [31:0] v;
        logic [6:0]  trace;
        logic [63:0] held_data;
        logic [4:0]  held_flags;
        int          stalls;

        vecs[0] = '{1'b1, 16'd20,  3,  0, 64'h0001020304050607, 3'd0, 1'b1, 1'b0};
        vecs[1] = '{1'b0, 16'd20,  3,  1, 64'h08090A0B0C0D0E0F, 3'd0, 1'b0, 1'b0};
        vecs[2] = '{1'b0, 16'd20,  3,  2, 64'h1011121300000000, 3'd4, 1'b0, 1'b1};
        vecs[3] = '{1'b1, 16'd8,   1,  0, 64'h0001020304050607, 3'd0, 1'b1, 1'b1};
        vecs[4] = '{1'b1, 16'd1,   1,  0, 64'h0000000000000000, 3'd7, 1'b1, 1'b1};
        vecs[5] = '{1'b1, 16'd9,   2,  0, 64'h0001020304050607, 3'd0, 1'b1, 1'b0};
        vecs[6] = '{1'b0, 16'd9,   2,  1, 64'h0800000000000000, 3'd7, 1'b0, 1'b1};
        vecs[7] = '{1'b1, 16'd264, 33, 31, 64'hF8F9FAFBFCFDFEFF, 3'd0, 1'b0, 1'b0};
        vecs[8] = '{1'b0, 16'd264, 33, 32, 64'h0001020304050607, 3'd0, 1'b0, 1'b1};

        // Reset state.
        repeat (2) @(negedge clk);
        check("rst valid", stream_out_valid, 0);
        check("rst sop", stream_out_startofpacket, 0);
        check("rst eop", stream_out_endofpacket, 0);
        check("rst data", stream_out_data, 0);
        check("rst empty", stream_out_empty, 0);
        check("rst readdatavalid", csr_readdatavalid, 0);
        check("rst readdata", csr_readdata, 0);
        check("rst waitrequest", csr_waitrequest, 1);
        tick();
        reset_n = 1'b1;
        @(negedge clk);
        check("post-rst waitrequest", csr_waitrequest, 0);
        tick();
        csr_rd(CSR_ADDR_LEN, v);  check("rst LEN", v, 64);
        csr_rd(CSR_ADDR_CNT, v);  check("rst CNT", v, 1);
        csr_rd(CSR_ADDR_SENT, v); check("rst SENT", v, 0);
        csr_rd(CSR_ADDR_CTRL, v); check("rst CTRL", v, 0);

        stream_out_ready = 1'b1;

        // Start ignored with LEN=0 or CNT=0.
        wr(CSR_ADDR_LEN, 0);
        wr(CSR_ADDR_CTRL, 1);
        csr_rd(CSR_ADDR_CTRL, v); check("start ignored len0", v, 0);
        wr(CSR_ADDR_LEN, 20);
        wr(CSR_ADDR_CNT, 0);
        wr(CSR_ADDR_CTRL, 1);
        csr_rd(CSR_ADDR_CTRL, v); check("start ignored cnt0", v, 0);

        // Table-driven single-packet beats.
        for (int i = 0; i < NV; i++) begin
            if (vecs[i].run) begin
                q_beats.delete();
                cap_en = 1'b1;
                wr(CSR_ADDR_LEN, {16'h0, vecs[i].len});
                wr(CSR_ADDR_CNT, 1);
                wr(CSR_ADDR_CTRL, 1);
                wait_idle();
                cap_en = 1'b0;
                check($sformatf("len%0d beat count", vecs[i].len), q_beats.size(), vecs[i].n_beats);
                csr_rd(CSR_ADDR_SENT, v);
                check($sformatf("len%0d SENT", vecs[i].len), v, 1);
            end
            if (vecs[i].beat < q_beats.size()) begin
                check($sformatf("len%0d beat%0d data", vecs[i].len, vecs[i].beat),
                      q_beats[vecs[i].beat].data, vecs[i].data);
                check($sformatf("len%0d beat%0d empty/sop/eop", vecs[i].len, vecs[i].beat),
                      {q_beats[vecs[i].beat].empty, q_beats[vecs[i].beat].sop, q_beats[vecs[i].beat].eop},
                      {vecs[i].empty, vecs[i].sop, vecs[i].eop});
            end else begin
                n_cmp++;
                n_err++;
                $display("FAIL len%0d beat%0d: missing, got %0d beats", vecs[i].len, vecs[i].beat, q_beats.size());
            end
        end

        // Three 1-beat packets with one idle cycle between them.
        q_beats.delete();
        cap_en = 1'b1;
        wr(CSR_ADDR_LEN, 8);
        wr(CSR_ADDR_CNT, 3);
        wr(CSR_ADDR_CTRL, 1);
        for (int c = 0; c < 7; c++) begin
            @(negedge clk);
            trace[6-c] = stream_out_valid;
        end
        tick();
        check("cnt3 valid trace", trace, 7'b1010100);
        wait_idle();
        cap_en = 1'b0;
        check("cnt3 beat count", q_beats.size(), 3);
        for (int b = 0; b < 3 && b < q_beats.size(); b++) begin
            check($sformatf("cnt3 pkt%0d data", b), q_beats[b].data, 64'h0001020304050607);
            check($sformatf("cnt3 pkt%0d empty/sop/eop", b),
                  {q_beats[b].empty, q_beats[b].sop, q_beats[b].eop}, 5'b00011);
        end
        csr_rd(CSR_ADDR_SENT, v); check("cnt3 SENT", v, 3);

        // LEN=24 with ready 1,0,0,1.
        q_beats.delete();
        cap_en = 1'b1;
        wr(CSR_ADDR_LEN, 24);
        wr(CSR_ADDR_CNT, 1);
        wr(CSR_ADDR_CTRL, 1);
        @(negedge clk);
        check("stall beat1 sop", stream_out_startofpacket, 1);
        tick();
        stream_out_ready = 1'b0;
        @(negedge clk);
        held_data  = stream_out_data;
        held_flags = {stream_out_empty, stream_out_startofpacket, stream_out_endofpacket};
        check("stall beat2 data", held_data, 64'h08090A0B0C0D0E0F);
        tick();
        @(negedge clk);
        check("stall hold data c3", stream_out_data, held_data);
        check("stall hold flags c3", {stream_out_empty, stream_out_startofpacket, stream_out_endofpacket}, held_flags);
        tick();
        stream_out_ready = 1'b1;
        @(negedge clk);
        check("stall hold data c4", stream_out_data, held_data);
        check("stall hold flags c4", {stream_out_empty, stream_out_startofpacket, stream_out_endofpacket}, held_flags);
        tick();
        wait_idle();
        cap_en = 1'b0;
        check("stall beat count", q_beats.size(), 3);
        if (q_beats.size() == 3) begin
            check("stall rx beat0", q_beats[0].data, 64'h0001020304050607);
            check("stall rx beat1", q_beats[1].data, 64'h08090A0B0C0D0E0F);
            check("stall rx beat2", q_beats[2].data, 64'h1011121314151617);
            check("stall rx beat2 empty/sop/eop", {q_beats[2].empty, q_beats[2].sop, q_beats[2].eop}, 5'b00001);
        end
        csr_rd(CSR_ADDR_CTRL, v);
        check("stall counter", v[31:16], EXP_STALL);

        // Abort during beat 2 of packet 1 with CNT=10.
        q_beats.delete();
        cap_en = 1'b1;
        wr(CSR_ADDR_LEN, 20);
        wr(CSR_ADDR_CNT, 10);
        wr(CSR_ADDR_CTRL, 1);
        @(negedge clk);
        tick();
        wr(CSR_ADDR_CTRL, 2);
        wait_idle();
        cap_en = 1'b0;
        check("abort beat count", q_beats.size(), 3);
        if (q_beats.size() > 0)
            check("abort last eop", q_beats[q_beats.size()-1].eop, 1);
        csr_rd(CSR_ADDR_SENT, v); check("abort SENT", v, 1);

        // LEN write while busy stalls until IDLE (2 x 5 beats + 2 gaps).
        wr(CSR_ADDR_LEN, 40);
        wr(CSR_ADDR_CNT, 2);
        wr(CSR_ADDR_CTRL, 1);
        csr_wr(CSR_ADDR_LEN, 16, stalls);
        check("busy write stall cycles", stalls, 12);
        csr_rd(CSR_ADDR_CTRL, v); check("busy write then idle", v[CTRL_BUSY_BIT], 0);
        csr_rd(CSR_ADDR_LEN, v);  check("busy write LEN", v, 16);
        csr_rd(CSR_ADDR_SENT, v); check("busy write SENT", v, 2);

        // Asynchronous reset mid-packet.
        wr(CSR_ADDR_LEN, 40);
        wr(CSR_ADDR_CNT, 1);
        wr(CSR_ADDR_CTRL, 1);
        @(negedge clk);
        check("pre-reset valid", stream_out_valid, 1);
        #2;
        reset_n = 1'b0;
        #1;
        check("async reset valid", stream_out_valid, 0);
        check("async reset data", stream_out_data, 0);
        check("async reset sop", stream_out_startofpacket, 0);
        check("async reset waitrequest", csr_waitrequest, 1);
        tick();
        reset_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check($sformatf("no resume c%0d", c), stream_out_valid, 0);
        end
        tick();
        csr_rd(CSR_ADDR_LEN, v);  check("reset LEN", v, 64);
        csr_rd(CSR_ADDR_CNT, v);  check("reset CNT", v, 1);
        csr_rd(CSR_ADDR_SENT, v); check("reset SENT", v, 0);
        csr_rd(CSR_ADDR_CTRL, v); check("reset CTRL", v, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
